operand_stream_tx: RTL and testbench

Synthesizable transmitter for one operand stream (A or B) of the accelerator's input interface. It reads a block of `length` words from a local operand SRAM with 1-cycle read latency and drives them on a valid/ready stream with a zero flag. Zero words are flagged rather than toggled on the data bus: `out_data` holds the last non-zero word. A start/running/done handshake lets the top-level controller launch one transfer per layer tile.

---
 rtl/operand_stream_tx.sv | 215 +++++++++++++++++++++
 tb/tb_operand_stream_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_tx.sv
// Operand stream transmitter: reads a block of words from a 1-cycle-latency SRAM
// and presents them on a valid/ready stream, flagging zero words instead of driving them.
module operand_stream_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  running,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_zero_flag,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [LEN_WIDTH-1:0]  length_r;
    logic [LEN_WIDTH-1:0]  issue_cnt_r;
    logic [LEN_WIDTH-1:0]  deliv_cnt_r;
    logic [ADDR_WIDTH-1:0] next_addr_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  re_d_r;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [DATA_WIDTH-1:0] tail_data_r;
    logic                  head_zero_r;
    logic                  tail_zero_r;
    logic [1:0]            fifo_cnt_r;
    logic [DATA_WIDTH-1:0] last_nz_r;
    logic                  running_r;
    logic                  done_r;

    logic                  valid_s;
    logic                  hs_s;
    logic                  last_hs_s;
    logic                  credit_s;
    logic                  issue_s;
    logic                  in_zero_s;
    logic [1:0]            occ_s;

    // Handshake, credit and issue decisions
    always_comb begin
        valid_s   = (fifo_cnt_r != 2'd0);
        hs_s      = valid_s && out_ready;
        last_hs_s = hs_s && (deliv_cnt_r == (length_r - LEN_WIDTH'(1)));
        occ_s     = fifo_cnt_r + {1'b0, re_d_r} - {1'b0, hs_s};
        credit_s  = (occ_s < 2'd2);
        issue_s   = (state_r == RUN) && credit_s;
        in_zero_s = (mem_rdata == {DATA_WIDTH{1'b0}});
    end

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (length != {LEN_WIDTH{1'b0}})) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && ((issue_cnt_r + LEN_WIDTH'(1)) == length_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (last_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Transfer parameters, address and progress counters
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            length_r    <= {LEN_WIDTH{1'b0}};
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            deliv_cnt_r <= {LEN_WIDTH{1'b0}};
            next_addr_r <= {ADDR_WIDTH{1'b0}};
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            re_d_r      <= 1'b0;
        end else begin
            re_d_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                length_r    <= length;
                issue_cnt_r <= {LEN_WIDTH{1'b0}};
                deliv_cnt_r <= {LEN_WIDTH{1'b0}};
                next_addr_r <= base_addr;
            end else begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r + LEN_WIDTH'(1);
                    next_addr_r <= next_addr_r + ADDR_WIDTH'(1);
                    mem_addr_r  <= next_addr_r;
                end
                if (hs_s) begin
                    deliv_cnt_r <= deliv_cnt_r + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Two-entry skid FIFO of {word, zero}; head is the presented word
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_data_r <= {DATA_WIDTH{1'b0}};
            tail_data_r <= {DATA_WIDTH{1'b0}};
            head_zero_r <= 1'b0;
            tail_zero_r <= 1'b0;
            fifo_cnt_r  <= 2'd0;
        end else begin
            case ({re_d_r, hs_s})
                2'b10: begin
                    if (fifo_cnt_r == 2'd0) begin
                        head_data_r <= mem_rdata;
                        head_zero_r <= in_zero_s;
                    end else begin
                        tail_data_r <= mem_rdata;
                        tail_zero_r <= in_zero_s;
                    end
                    fifo_cnt_r <= fifo_cnt_r + 2'd1;
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_zero_r <= tail_zero_r;
                    fifo_cnt_r  <= fifo_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_r == 2'd1) begin
                        head_data_r <= mem_rdata;
                        head_zero_r <= in_zero_s;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_zero_r <= tail_zero_r;
                        tail_data_r <= mem_rdata;
                        tail_zero_r <= in_zero_s;
                    end
                end
                default: begin
                    fifo_cnt_r <= fifo_cnt_r;
                end
            endcase
        end
    end

    // Held data, running flag and completion pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_nz_r <= {DATA_WIDTH{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (hs_s && !head_zero_r) begin
                last_nz_r <= head_data_r;
            end
            if ((state_r == IDLE) && start) begin
                if (length == {LEN_WIDTH{1'b0}}) begin
                    done_r <= 1'b1;
                end else begin
                    running_r <= 1'b1;
                end
            end else if ((state_r == DRAIN) && last_hs_s) begin
                running_r <= 1'b0;
                done_r    <= 1'b1;
            end
        end
    end

    // Output drive; the bus only moves when a non-zero word reaches the head
    always_comb begin
        running       = running_r;
        done          = done_r;
        mem_re        = issue_s;
        mem_addr      = issue_s ? next_addr_r : mem_addr_r;
        out_valid     = valid_s;
        out_zero_flag = valid_s && head_zero_r;
        if (valid_s && !head_zero_r) begin
            out_data = head_data_r;
        end else begin
            out_data = last_nz_r;
        end
    end

endmodule

// File: tb/tb_operand_stream_tx.sv
// Directed testbench for operand_stream_tx with a behavioural 1-cycle-latency SRAM.
module tb_operand_stream_tx;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic        running;
    logic        done;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] out_data;
    logic        out_zero_flag;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [15:0] sram [0:65535];

    int checks = 0;
    int failures = 0;

    logic [15:0] got_data[$];
    logic        got_zero[$];
    int          hs_c[$];
    logic [15:0] re_addr[$];
    int          done_c;
    int          done_pulses;
    logic        running_at0;
    logic        running_at_done;
    logic        valid_seen;
    int          unstable;

    operand_stream_tx #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .base_addr(base_addr),
        .length(length), .running(running), .done(done), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
        .out_zero_flag(out_zero_flag), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    // Runs one transfer; cycle index c counts edges after the start edge E
    task automatic run_xfer(input logic [15:0] base, input logic [15:0] len,
                            input int mode, input int restart_c);
        logic [3:0]  pat;
        logic        prev_stall;
        logic [15:0] pd;
        logic        pz;
        logic        pv;
        pat = 4'b1001;
        got_data.delete(); got_zero.delete(); hs_c.delete(); re_addr.delete();
        done_c = -1; done_pulses = 0; unstable = 0; valid_seen = 1'b0;
        running_at0 = 1'b0; running_at_done = 1'b1; prev_stall = 1'b0;
        pd = 16'h0000; pz = 1'b0; pv = 1'b0;
        @(posedge clk); #1;
        base_addr = base; length = len; start = 1'b1;
        out_ready = (mode == 0) ? 1'b1 : pat[0];
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            start = (c == restart_c);
            length = (c == restart_c) ? len + 16'd5 : (len ^ 16'h00FF);
            base_addr = base + 16'h0100;
            out_ready = (mode == 0) ? 1'b1 : pat[c % 4];
            #1;
            if (c == 0) running_at0 = running;
            if (prev_stall && ((out_data !== pd) || (out_zero_flag !== pz) || (out_valid !== pv)))
                unstable++;
            prev_stall = out_valid && !out_ready;
            pd = out_data; pz = out_zero_flag; pv = out_valid;
            if (out_valid) valid_seen = 1'b1;
            if (mem_re) re_addr.push_back(mem_addr);
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_zero.push_back(out_zero_flag);
                hs_c.push_back(c + 1);
            end
            if (done) begin
                done_pulses++;
                if (done_c < 0) begin
                    done_c = c;
                    running_at_done = running;
                end
            end
            if ((done_c >= 0) && (c >= done_c + 3)) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #12;
        checks++;
        if ({running, done, mem_re, mem_addr, out_data, out_zero_flag, out_valid} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h exp 0",
                     {running, done, mem_re, mem_addr, out_data, out_zero_flag, out_valid});
        end
        @(posedge clk); #1 arst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [4] = '{16'd5, 16'd7, 16'd9, 16'd11};
        for (int i = 0; i < 4; i++) sram[16'h0010 + i] = exp_d[i];
        run_xfer(16'h0010, 16'd4, 0, -1);
        checks++;
        if (got_data.size() != 4) begin
            failures++; $display("FAIL basic_count got %0d exp 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ((got_data[i] !== exp_d[i]) || (hs_c[i] != 3 + i)) begin
                    failures++;
                    $display("FAIL basic_word%0d got %h@%0d exp %h@%0d", i, got_data[i], hs_c[i], exp_d[i], 3 + i);
                end
            end
        end
        checks++;
        if ((done_c != 6) || (done_pulses != 1)) begin
            failures++; $display("FAIL basic_done got c=%0d n=%0d exp c=6 n=1", done_c, done_pulses);
        end
        checks++;
        if ((re_addr.size() != 4) || (re_addr[0] !== 16'h0010) || (re_addr[3] !== 16'h0013)) begin
            failures++; $display("FAIL basic_reads got n=%0d exp 4 (0x10..0x13)", re_addr.size());
        end
        checks++;
        if ((running_at0 !== 1'b1) || (running_at_done !== 1'b0)) begin
            failures++; $display("FAIL basic_running got %b/%b exp 1/0", running_at0, running_at_done);
        end
    endtask

    task automatic test_zero_compress();
        logic [15:0] src [4] = '{16'd3, 16'd0, 16'd0, 16'd8};
        logic [15:0] exp_d [4] = '{16'd3, 16'd3, 16'd3, 16'd8};
        logic [3:0]  exp_z = 4'b0110;
        for (int i = 0; i < 4; i++) sram[16'h0020 + i] = src[i];
        run_xfer(16'h0020, 16'd4, 0, -1);
        checks++;
        if (got_data.size() != 4) begin
            failures++; $display("FAIL zero_count got %0d exp 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ((got_data[i] !== exp_d[i]) || (got_zero[i] !== exp_z[3 - i])) begin
                    failures++;
                    $display("FAIL zero_word%0d got %h/%b exp %h/%b", i, got_data[i], got_zero[i], exp_d[i], exp_z[3 - i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        for (int i = 0; i < 16; i++) sram[16'h0100 + i] = 16'h1000 + 16'(i);
        run_xfer(16'h0100, 16'd16, 1, -1);
        checks++;
        if (got_data.size() != 16) begin
            failures++; $display("FAIL bp_count got %0d exp 16", got_data.size());
        end
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 16'h1000 + 16'(i)) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_order got %0d wrong words exp 0", bad);
        end
        checks++;
        if (unstable != 0) begin
            failures++; $display("FAIL bp_stable got %0d changes while stalled exp 0", unstable);
        end
        checks++;
        if ((re_addr.size() != 16) || (re_addr[15] !== 16'h010F) || (done_pulses != 1)) begin
            failures++; $display("FAIL bp_reads got n=%0d exp 16, done pulses %0d exp 1", re_addr.size(), done_pulses);
        end
    endtask

    task automatic test_zero_length();
        run_xfer(16'h0050, 16'd0, 0, -1);
        checks++;
        if ((done_c != 0) || (done_pulses != 1)) begin
            failures++; $display("FAIL zlen_done got c=%0d n=%0d exp c=0 n=1", done_c, done_pulses);
        end
        checks++;
        if ((re_addr.size() != 0) || (valid_seen !== 1'b0) || (running_at0 !== 1'b0)) begin
            failures++;
            $display("FAIL zlen_quiet got reads=%0d valid=%b running=%b exp 0/0/0", re_addr.size(), valid_seen, running_at0);
        end
    endtask

    task automatic test_wrap();
        sram[16'hFFFE] = 16'h00A1; sram[16'hFFFF] = 16'h00A2; sram[16'h0000] = 16'h00A3;
        run_xfer(16'hFFFE, 16'd3, 0, -1);
        checks++;
        if ((re_addr.size() != 3) || (re_addr[0] !== 16'hFFFE) || (re_addr[1] !== 16'hFFFF) || (re_addr[2] !== 16'h0000)) begin
            failures++; $display("FAIL wrap_addr got n=%0d exp FFFE,FFFF,0000", re_addr.size());
        end
        checks++;
        if ((got_data.size() != 3) || (got_data[2] !== 16'h00A3)) begin
            failures++; $display("FAIL wrap_data got n=%0d exp 3 ending A3", got_data.size());
        end
    endtask

    task automatic test_restart_ignored();
        for (int i = 0; i < 12; i++) sram[16'h0040 + i] = 16'h0400 + 16'(i);
        run_xfer(16'h0040, 16'd4, 0, 2);
        checks++;
        if ((got_data.size() != 4) || (re_addr.size() != 4) || (done_c != 6)) begin
            failures++;
            $display("FAIL restart got words=%0d reads=%0d done=%0d exp 4/4/6", got_data.size(), re_addr.size(), done_c);
        end
        checks++;
        if ((got_data.size() == 4) && (got_data[3] !== 16'h0403)) begin
            failures++; $display("FAIL restart_last got %h exp 0403", got_data[3]);
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 8; i++) sram[16'h0200 + i] = 16'h0020 + 16'(i);
        for (int i = 0; i < 3; i++) sram[16'h0300 + i] = 16'h0031 + 16'(i);
        @(posedge clk); #1;
        base_addr = 16'h0200; length = 16'd8; start = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({running, done, mem_re, mem_addr, out_data, out_zero_flag, out_valid} !== 36'd0) begin
            failures++;
            $display("FAIL midreset_outputs got %h exp 0",
                     {running, done, mem_re, mem_addr, out_data, out_zero_flag, out_valid});
        end
        @(posedge clk); @(posedge clk); #1 arst_n = 1'b1;
        run_xfer(16'h0300, 16'd3, 0, -1);
        checks++;
        if ((got_data.size() != 3) || (got_data[0] !== 16'h0031) || (re_addr[0] !== 16'h0300) || (done_c != 5)) begin
            failures++;
            $display("FAIL midreset_restart got n=%0d first=%h done=%0d exp 3/0031/5",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 16'hxxxx, done_c);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_compress();
        test_backpressure();
        test_zero_length();
        test_wrap();
        test_restart_ignored();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
